// File: rtl/wb_daq_channel_arbiter.sv
// Round-robin arbiter for the DAQ aggregation FIFO write port. Each winning sample
// is tagged with its channel index, and a running count of written samples is kept.
module wb_daq_channel_arbiter #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_WIDTH = 24
) (
  input  logic                                 wb_clk,
  input  logic                                 wb_rst_n,
  input  logic                                 enable,
  input  logic [NUM_CHANNELS-1:0]              channel_enable,
  input  logic [NUM_CHANNELS-1:0]              channel_req,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] channel_data,
  output logic [NUM_CHANNELS-1:0]              channel_grant,
  input  logic                                 fifo_full,
  output logic                                 fifo_wr,
  output logic [31:0]                          fifo_data,
  input  logic                                 clear_count,
  output logic [31:0]                          sample_count,
  output logic                                 busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);
  localparam int unsigned TAG_W = 8;
  localparam int unsigned SMP_W = 24;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         sel_idx_q, sel_idx_d;
  logic                     fifo_wr_q, fifo_wr_d;
  logic [NUM_CHANNELS-1:0]  grant_q, grant_d;
  logic [31:0]              fifo_data_q, fifo_data_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [NUM_CHANNELS-1:0]  masked_req_c;
  logic                     win_found_c;
  logic [IDX_W-1:0]         win_idx_c;
  logic [IDX_W-1:0]         cand_idx_c;
  logic [SAMPLE_WIDTH-1:0]  sample_c;

  assign masked_req_c = channel_req & channel_enable;
  assign sample_c     = channel_data[32'(win_idx_c)*SAMPLE_WIDTH +: SAMPLE_WIDTH];

  // First enabled requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_idx_c  = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      cand_idx_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_CHANNELS);
      if (!win_found_c && masked_req_c[cand_idx_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_idx_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_idx_d   = sel_idx_q;
    fifo_wr_d   = 1'b0;
    grant_d     = '0;
    fifo_data_d = fifo_data_q;
    count_d     = count_q;

    case (state_q)
      ST_IDLE: begin
        if (enable && win_found_c) begin
          sel_idx_d   = win_idx_c;
          fifo_data_d = {TAG_W'(win_idx_c), SMP_W'(sample_c)};
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!fifo_full) begin
          fifo_wr_d = 1'b1;
          grant_d   = NUM_CHANNELS'(1) << sel_idx_q;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        count_d  = count_q + CNT_W'(1);
        rr_ptr_d = IDX_W'((32'(sel_idx_q) + 32'd1) % NUM_CHANNELS);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear coinciding with the ACK increment takes priority.
    if (clear_count) count_d = '0;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      sel_idx_q   <= '0;
      fifo_wr_q   <= 1'b0;
      grant_q     <= '0;
      fifo_data_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_idx_q   <= sel_idx_d;
      fifo_wr_q   <= fifo_wr_d;
      grant_q     <= grant_d;
      fifo_data_q <= fifo_data_d;
      count_q     <= count_d;
    end
  end

  assign channel_grant = grant_q;
  assign fifo_wr       = fifo_wr_q;
  assign fifo_data     = fifo_data_q;
  assign sample_count  = count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_daq_channel_arbiter.sv
// Self-checking bench for wb_daq_channel_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model of the arbiter.
module tb_wb_daq_channel_arbiter;

  localparam int N  = 4;
  localparam int SW = 24;

  logic          wb_clk;
  logic          wb_rst_n;
  logic          enable;
  logic [N-1:0]  channel_enable;
  logic [N-1:0]  channel_req;
  logic [N*SW-1:0] channel_data;
  logic [N-1:0]  channel_grant;
  logic          fifo_full;
  logic          fifo_wr;
  logic [31:0]   fifo_data;
  logic          clear_count;
  logic [31:0]   sample_count;
  logic          busy;

  wb_daq_channel_arbiter #(.NUM_CHANNELS(N), .SAMPLE_WIDTH(SW)) dut (
    .wb_clk         (wb_clk),
    .wb_rst_n       (wb_rst_n),
    .enable         (enable),
    .channel_enable (channel_enable),
    .channel_req    (channel_req),
    .channel_data   (channel_data),
    .channel_grant  (channel_grant),
    .fifo_full      (fifo_full),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .clear_count    (clear_count),
    .sample_count   (sample_count),
    .busy           (busy)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  int vecs = 0;
  int errs = 0;

  // Reference model: one outstanding transaction, described by what it has done so far.
  bit          t_active, t_wrote;
  int          m_sel, m_ptr;
  logic        m_wr;
  logic [N-1:0] m_grant;
  logic [31:0] m_data, m_count;
  logic        m_busy;

  // Channel sources: 0 manual, 1 always re-request, 2 random re-request.
  int src_mode = 0;
  int hold [N];

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - ptr + N) % N) < bestd) begin
        bestd = (i - ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    t_active = 0; t_wrote = 0; m_sel = 0; m_ptr = 0;
    m_wr = 1'b0; m_grant = '0; m_data = '0; m_count = '0; m_busy = 1'b0;
  endtask

  // One clock: snapshot inputs at the edge, advance the model, then let sources react.
  task automatic step();
    logic s_en, s_full, s_clr;
    logic [N-1:0] s_mask, s_req;
    logic [N*SW-1:0] s_data;
    s_en = enable; s_full = fifo_full; s_clr = clear_count;
    s_mask = channel_enable; s_req = channel_req; s_data = channel_data;
    @(posedge wb_clk);
    #1;
    if (!t_active) begin
      if (s_en && (s_req & s_mask) != '0) begin
        m_sel    = pick(s_req & s_mask, m_ptr);
        m_data   = {8'(m_sel), s_data[m_sel*SW +: SW]};
        t_active = 1;
        t_wrote  = 0;
      end
    end else if (!t_wrote) begin
      if (!s_full) begin
        t_wrote = 1;
        m_wr    = 1'b1;
        m_grant = N'(1) << m_sel;
      end
    end else begin
      t_active = 0; t_wrote = 0;
      m_wr = 1'b0; m_grant = '0;
      m_count = m_count + 32'd1;
      m_ptr = (m_sel + 1) % N;
    end
    if (s_clr) m_count = '0;
    m_busy = t_active;
    for (int i = 0; i < N; i++) begin
      if (channel_grant[i]) begin
        channel_req[i] = 1'b0;
        hold[i] = 1;
      end else if (hold[i] > 0) begin
        hold[i]--;
      end else if (src_mode != 0 && !channel_req[i] &&
                   (src_mode == 1 || $urandom_range(0, 2) == 0)) begin
        channel_req[i] = 1'b1;
        channel_data[i*SW +: SW] = 24'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    enable = 1'b0; channel_enable = '0; channel_req = '0; channel_data = '0;
    fifo_full = 1'b0; clear_count = 1'b0; src_mode = 0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    model_reset();
    repeat (2) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
  endtask

  task automatic drain();
    src_mode = 0; channel_req = '0; clear_count = 1'b0; fifo_full = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    vecs++;
    if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {1'b0, 4'b0, 32'h0, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset_state: wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, expected all zero",
               fifo_wr, channel_grant, fifo_data, sample_count, busy);
    end
    do_reset();
  endtask

  task automatic test_single_request();
    do_reset();
    enable = 1'b1; channel_enable = 4'hF;
    channel_data = {$urandom, $urandom, $urandom};
    channel_data[2*SW +: SW] = 24'hABCDEF;
    channel_req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      step();
      vecs++;
      if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {m_wr, m_grant, m_data, m_count, m_busy}) begin
        errs++;
        $display("FAIL single_model c%0d: got wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, want wr=%0b gnt=%b data=%h cnt=%0d busy=%0b",
                 c, fifo_wr, channel_grant, fifo_data, sample_count, busy, m_wr, m_grant, m_data, m_count, m_busy);
      end
      vecs++;
      if (fifo_wr !== (c == 2)) begin
        errs++;
        $display("FAIL single_latency c%0d: fifo_wr=%0b, expected %0b", c, fifo_wr, c == 2);
      end
      if (c == 2) begin
        vecs++;
        if (fifo_data !== 32'h02ABCDEF || channel_grant !== 4'b0100) begin
          errs++;
          $display("FAIL single_write: data=%h gnt=%b, expected 02abcdef 0100", fifo_data, channel_grant);
        end
      end
    end
    vecs++;
    if (sample_count !== 32'd1) begin
      errs++;
      $display("FAIL single_count: sample_count=%0d, expected 1", sample_count);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int at[$];
    do_reset();
    enable = 1'b1; channel_enable = 4'hF;
    channel_data = {$urandom, $urandom, $urandom};
    channel_req = 4'hF; src_mode = 1;
    for (int c = 1; c <= 18; c++) begin
      step();
      vecs++;
      if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {m_wr, m_grant, m_data, m_count, m_busy}) begin
        errs++;
        $display("FAIL rr_model c%0d: got wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, want wr=%0b gnt=%b data=%h cnt=%0d busy=%0b",
                 c, fifo_wr, channel_grant, fifo_data, sample_count, busy, m_wr, m_grant, m_data, m_count, m_busy);
      end
      for (int i = 0; i < N; i++) if (channel_grant[i]) begin order.push_back(i); at.push_back(c); end
    end
    vecs++;
    if (order.size() != 6) begin
      errs++;
      $display("FAIL rr_grant_count: %0d grants, expected 6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vecs++;
        if (order[k] != k % N || at[k] != 2 + 3*k) begin
          errs++;
          $display("FAIL rr_order #%0d: ch%0d at cycle %0d, expected ch%0d at cycle %0d", k, order[k], at[k], k % N, 2 + 3*k);
        end
      end
    end
    vecs++;
    if (sample_count !== 32'd6) begin
      errs++;
      $display("FAIL rr_count: sample_count=%0d, expected 6", sample_count);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int ch;
    logic [31:0] held;
    ch = $urandom_range(0, N-1);
    enable = 1'b1; channel_enable = 4'hF; fifo_full = 1'b1;
    channel_data[ch*SW +: SW] = 24'($urandom);
    channel_req = N'(1) << ch;
    step();
    held = fifo_data;
    vecs++;
    if (held !== {8'(ch), channel_data[ch*SW +: SW]} || busy !== 1'b1) begin
      errs++;
      $display("FAIL bp_capture: data=%h busy=%0b, expected %h busy=1", held, busy, {8'(ch), channel_data[ch*SW +: SW]});
    end
    for (int c = 1; c <= 5; c++) begin
      channel_data[ch*SW +: SW] = 24'($urandom);
      step();
      vecs++;
      if (fifo_wr !== 1'b0 || channel_grant !== '0 || busy !== 1'b1 || fifo_data !== held) begin
        errs++;
        $display("FAIL bp_stall c%0d: wr=%0b gnt=%b busy=%0b data=%h, expected 0 0 1 %h", c, fifo_wr, channel_grant, busy, fifo_data, held);
      end
    end
    fifo_full = 1'b0;
    step();
    vecs++;
    if (fifo_wr !== 1'b1 || channel_grant !== N'(1) << ch || fifo_data !== held) begin
      errs++;
      $display("FAIL bp_release: wr=%0b gnt=%b data=%h, expected 1 %b %h", fifo_wr, channel_grant, fifo_data, N'(1) << ch, held);
    end
    vecs++;
    if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {m_wr, m_grant, m_data, m_count, m_busy}) begin
      errs++;
      $display("FAIL bp_model: got wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, want wr=%0b gnt=%b data=%h cnt=%0d busy=%0b",
               fifo_wr, channel_grant, fifo_data, sample_count, busy, m_wr, m_grant, m_data, m_count, m_busy);
    end
    drain();
  endtask

  task automatic test_mask_enable();
    int prev = -1;
    bit found = 0;
    enable = 1'b1; channel_enable = 4'b1010;
    channel_req = 4'hF; src_mode = 1;
    for (int c = 1; c <= 15; c++) begin
      step();
      for (int i = 0; i < N; i++) if (channel_grant[i]) begin
        vecs++;
        if ((i != 1 && i != 3) || i == prev) begin
          errs++;
          $display("FAIL mask_grant c%0d: granted ch%0d after ch%0d, expected alternating 1/3", c, i, prev);
        end
        prev = i;
      end
    end
    enable = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      vecs++;
      if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {m_wr, m_grant, m_data, m_count, m_busy} ||
          (c > 3 && fifo_wr !== 1'b0)) begin
        errs++;
        $display("FAIL enable_off c%0d: got wr=%0b gnt=%b cnt=%0d busy=%0b, want wr=%0b gnt=%b cnt=%0d busy=%0b",
                 c, fifo_wr, channel_grant, sample_count, busy, m_wr, m_grant, m_count, m_busy);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 6 && !found; c++) begin
      step();
      if (busy === 1'b1 && fifo_wr === 1'b0) found = 1;
    end
    vecs++;
    if (!found) begin
      errs++;
      $display("FAIL enable_wait_reach: busy=%0b wr=%0b, expected to reach a waiting transaction", busy, fifo_wr);
    end else begin
      enable = 1'b0;
      step();
      vecs++;
      if (fifo_wr !== 1'b1 || channel_grant !== m_grant) begin
        errs++;
        $display("FAIL enable_drop_in_wait: wr=%0b gnt=%b, expected 1 %b", fifo_wr, channel_grant, m_grant);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r;
    int low;
    r = N'($urandom_range(1, 15));
    low = 0;
    while (!r[low]) low++;
    enable = 1'b1; channel_enable = 4'hF;
    channel_data = {$urandom, $urandom, $urandom};
    channel_req = r;
    step();
    vecs++;
    if (busy !== 1'b1 || fifo_wr !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_wait: busy=%0b wr=%0b, expected 1 0", busy, fifo_wr);
    end
    #2 wb_rst_n = 1'b0;
    #1;
    model_reset();
    vecs++;
    if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {1'b0, 4'b0, 32'h0, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL rstmid_async: wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, expected all zero",
               fifo_wr, channel_grant, fifo_data, sample_count, busy);
    end
    repeat (2) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
    step();
    step();
    vecs++;
    if (channel_grant !== N'(1) << low || fifo_wr !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_first_grant: gnt=%b wr=%0b, expected %b 1 for requests %b", channel_grant, fifo_wr, N'(1) << low, r);
    end
    drain();
  endtask

  task automatic test_counter_clear();
    bit ok = 0;
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    enable = 1'b1; channel_enable = 4'b0001; channel_req = 4'b0001; src_mode = 1;
    for (int c = 0; c < 60 && m_count != 32'd7; c++) step();
    for (int c = 0; c < 6 && !ok; c++) begin
      step();
      if (channel_grant !== '0) ok = 1;
    end
    vecs++;
    if (!ok || sample_count !== 32'd7) begin
      errs++;
      $display("FAIL clr_setup: ack_seen=%0b cnt=%0d, expected ACK with count 7", ok, sample_count);
    end
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    vecs++;
    if (sample_count !== 32'd0) begin
      errs++;
      $display("FAIL clr_vs_ack: sample_count=%0d, expected 0", sample_count);
    end
    ok = 0;
    for (int c = 0; c < 6 && !ok; c++) begin
      step();
      if (fifo_wr === 1'b1) ok = 1;
    end
    step();
    vecs++;
    if (!ok || sample_count !== 32'd1) begin
      errs++;
      $display("FAIL clr_next_write: wr_seen=%0b cnt=%0d, expected 1", ok, sample_count);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1; channel_enable = 4'hF; src_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      step();
      vecs++;
      if ({fifo_wr, channel_grant, fifo_data, sample_count, busy} !== {m_wr, m_grant, m_data, m_count, m_busy}) begin
        errs++;
        $display("FAIL random c%0d: got wr=%0b gnt=%b data=%h cnt=%0d busy=%0b, want wr=%0b gnt=%b data=%h cnt=%0d busy=%0b",
                 c, fifo_wr, channel_grant, fifo_data, sample_count, busy, m_wr, m_grant, m_data, m_count, m_busy);
      end
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) channel_enable = N'($urandom);
      fifo_full = ($urandom_range(0, 9) < 3);
      clear_count = ($urandom_range(0, 29) == 0);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_back_pressure();
    test_mask_enable();
    test_reset_mid();
    test_counter_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_daq_channel_arbiter.md
# wb_daq_channel_arbiter

Round-robin arbiter that shares the single write port of the DAQ aggregation FIFO among `NUM_CHANNELS` sample sources. It sits between the per-channel DAQ front ends and the aggregation FIFO. Each accepted sample is tagged with its channel index before it is pushed into the FIFO. The block also counts the samples it writes, for the Wishbone status register.

## Interface
- `NUM_CHANNELS`, default 4: number of requesting channels; legal range 2..8.
- `SAMPLE_WIDTH`, default 24: sample width per channel; legal range 1..24.
- `wb_clk`  in  1  system clock; all logic is on the rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global arbitration enable, from the control register.
- `channel_enable`  in  NUM_CHANNELS  per-channel enable mask.
- `channel_req`  in  NUM_CHANNELS  per-channel request; level, held with its data until granted.
- `channel_data`  in  NUM_CHANNELS*SAMPLE_WIDTH  packed samples; channel i occupies `[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]`.
- `channel_grant`  out  NUM_CHANNELS  one-hot, single-cycle acknowledge.
- `fifo_full`  in  1  FIFO back-pressure.
- `fifo_wr`  out  1  FIFO write strobe, single cycle.
- `fifo_data`  out  32  bits [31:24] are the channel index, zero-extended; bits [23:0] are the sample, zero-extended.
- `clear_count`  in  1  synchronous pulse that clears `sample_count`.
- `sample_count`  out  32  number of samples written to the FIFO; wraps at overflow.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: if `enable` and `|(channel_req & channel_enable)`, select the winner. Register `sel_idx` and `fifo_data <= {idx, sample}`, then go to WAIT. Otherwise stay in IDLE.
  - WAIT: if `fifo_full`=0, register `fifo_wr<=1` and `channel_grant[sel_idx]<=1`, then go to ACK. If `fifo_full`=1, hold in WAIT indefinitely.
  - ACK: `fifo_wr` and the grant are high for this cycle only. On exit, clear both, increment `sample_count`, set `rr_ptr <= (sel_idx+1) mod NUM_CHANNELS`, and go to IDLE.
- Round robin: search the masked requests from `rr_ptr` upward, modulo `NUM_CHANNELS`. The first set bit wins. A channel therefore never wins twice in a row while another enabled channel is requesting.
- Requests from channels with `channel_enable`=0 are ignored. They are never granted.
- `enable` and `channel_enable` gate only new selections. A transaction already in WAIT or ACK always completes.
- Sample data is captured in IDLE. Changes to `channel_data` after that capture do not affect the sample being written.
- `clear_count` in the same cycle as an ACK increment: clear wins, and the count becomes 0.
- Reset (asynchronous, including mid-transaction) sets the following, with no partial write:
  - state = IDLE
  - `rr_ptr`=0, `sel_idx`=0
  - `fifo_wr`=0, `channel_grant`=0, `fifo_data`=0
  - `sample_count`=0, `busy`=0

## Timing
- All outputs are registered. `busy` is decoded directly from the state register.
- Nominal transaction: the request is sampled in cycle N (IDLE), the FSM is in WAIT at N+1, and `fifo_wr`/grant are high in N+2 (ACK). The FSM returns to IDLE at N+3.
- Minimum latency from request to `fifo_wr` is 2 cycles. Maximum throughput is one sample per 3 cycles.
- Each cycle of `fifo_full`=1 in WAIT adds one cycle of latency.
- Channel handshake rule: a channel drops `channel_req` at the edge that ends the grant cycle. It may re-assert `channel_req` at the earliest one cycle later.
- `fifo_data` is stable from WAIT through ACK. It holds its last value in IDLE.

## Test plan
- **Single request:** reset, then `enable`=1, mask=4'hF. Channel 2 requests with data 24'hABCDEF. Required: `fifo_wr` exactly 2 cycles later, `fifo_data`=32'h02ABCDEF, grant=4'b0100 for 1 cycle, `sample_count`=1.
- **Round robin:** all 4 channels hold requests continuously (each re-requests after its grant). Required: grant order 0,1,2,3,0,1, one grant every 3 cycles, `sample_count`=6 after 18 cycles.
- **Back-pressure:** hold `fifo_full`=1 for 5 cycles while in WAIT. Required: no `fifo_wr` and no grant during the stall, `busy`=1 throughout, write 1 cycle after `fifo_full` drops, `fifo_data` unchanged across the stall.
- **Masking and enable:** mask=4'b1010 with all channels requesting. Required: only channels 1 and 3 are granted, alternating. With `enable`=0, no new `fifo_wr` occurs. Deasserting `enable` during WAIT still completes that one write.
- **Reset mid-transaction:** assert `wb_rst_n`=0 during WAIT. Required: all outputs 0 immediately (asynchronous), and after release the first grant goes to the lowest-index requester (`rr_ptr`=0).
- **Counter clear:** pulse `clear_count` in the same cycle as ACK with `sample_count`=7. Required: `sample_count`=0 afterwards, and the next write gives 1.
